// File: rtl/sys_bus_regs.sv
// rtl/sys_bus_regs.sv - system-bus register responder with programmable ack latency and masked event interrupt
module sys_bus_regs #(
    parameter int          AW       = 20,
    parameter int          ACK_LAT  = 1,
    parameter logic [31:0] ID_VAL   = 32'h5250_0001,
    parameter logic [7:0]  CTRL_RST = 8'h00
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_ack,
    output logic          sys_err,
    input  logic [7:0]    evt_i,
    input  logic [31:0]   status_i,
    output logic [7:0]    ctrl_o,
    output logic          irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [2:0] LAT_M1 = (ACK_LAT > 0) ? 3'(ACK_LAT - 1) : 3'd0;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:2] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   status_q;
    logic          wr_q;
    logic [2:0]    cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [7:0]    ctrl_q;
    logic [7:0]    flags_q;
    logic [7:0]    mask_q;
    logic [31:0]   scratch_q;
    logic [31:0]   wcnt_q;
    logic          irq_q;

    logic          req;
    logic [AW-1:2] cur_addr;
    logic [31:0]   cur_status;
    logic          dec_err;
    logic [31:0]   rd_mux;
    logic          commit;
    logic [7:0]    flag_clr;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^sys_addr[1:0];
    assign req = sys_wen | sys_ren;

    // With zero latency ACK is entered on the request edge itself, so read
    // data must come from the live request rather than the latched copy.
    assign cur_addr   = (state == S_IDLE) ? sys_addr[AW-1:2] : addr_q;
    assign cur_status = (state == S_IDLE) ? status_i : status_q;
    assign dec_err    = (|cur_addr[AW-1:8]) || (cur_addr[7:2] >= 6'd7);

    always_comb begin
        rd_mux = 32'h0;
        case (cur_addr[7:2])
            6'd0: rd_mux = ID_VAL;
            6'd1: rd_mux = {24'h0, ctrl_q};
            6'd2: rd_mux = cur_status;
            6'd3: rd_mux = {24'h0, flags_q};
            6'd4: rd_mux = {24'h0, mask_q};
            6'd5: rd_mux = scratch_q;
            6'd6: rd_mux = wcnt_q;
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req) state_nx = (ACK_LAT == 0) ? S_ACK : S_WAIT;
            S_WAIT: if (cnt_q == 3'd0) state_nx = S_ACK;
            S_ACK:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Any decoded write counts, including writes to read-only registers.
    assign commit   = (state == S_ACK) && wr_q && !err_q;
    assign flag_clr = (commit && addr_q[7:2] == 6'd3) ? wdata_q[7:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            status_q  <= 32'h0;
            wr_q      <= 1'b0;
            cnt_q     <= 3'd0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            ctrl_q    <= CTRL_RST;
            flags_q   <= 8'h00;
            mask_q    <= 8'h00;
            scratch_q <= 32'h0;
            wcnt_q    <= 32'h0;
            irq_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req) begin
                addr_q   <= sys_addr[AW-1:2];
                wdata_q  <= sys_wdata;
                status_q <= status_i;
                wr_q     <= sys_wen;
                cnt_q    <= LAT_M1;
            end else if (state == S_WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state_nx == S_ACK) begin
                rdata_q <= dec_err ? 32'h0 : rd_mux;
                err_q   <= dec_err;
            end
            if (commit) begin
                wcnt_q <= wcnt_q + 32'd1;
                case (addr_q[7:2])
                    6'd1: ctrl_q    <= wdata_q[7:0];
                    6'd4: mask_q    <= wdata_q[7:0];
                    6'd5: scratch_q <= wdata_q;
                    default: ;
                endcase
            end
            flags_q <= (flags_q & ~flag_clr) | evt_i;
            irq_q   <= |(flags_q & mask_q);
        end
    end

    assign sys_ack   = (state == S_ACK);
    assign sys_err   = sys_ack & err_q;
    assign sys_rdata = rdata_q;
    assign ctrl_o    = ctrl_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_sys_bus_regs.sv
// tb/tb_sys_bus_regs.sv - self-checking bench for sys_bus_regs at ack latencies 1, 0 and 7
module tb_sys_bus_regs;
    localparam int N  = 3;
    localparam int AW = 20;
    localparam logic [31:0] ID = 32'h5250_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn   [N];
    logic [AW-1:0] addr   [N];
    logic [31:0]   wdata  [N];
    logic          wen    [N];
    logic          ren    [N];
    logic [7:0]    evt    [N];
    logic [31:0]   status [N];
    logic [31:0]   rdata  [N];
    logic          ack    [N];
    logic          err    [N];
    logic [7:0]    ctrl   [N];
    logic          irq    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sys_bus_regs #(
            .AW(AW), .ACK_LAT(g == 0 ? 1 : (g == 1 ? 0 : 7)),
            .ID_VAL(ID), .CTRL_RST(8'h00)
        ) u_dut (
            .clk(clk), .rstn(rstn[g]), .sys_addr(addr[g]), .sys_wdata(wdata[g]),
            .sys_wen(wen[g]), .sys_ren(ren[g]), .sys_rdata(rdata[g]),
            .sys_ack(ack[g]), .sys_err(err[g]), .evt_i(evt[g]),
            .status_i(status[g]), .ctrl_o(ctrl[g]), .irq_o(irq[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 7);
    endfunction

    // Transaction-level reference: each instance holds one outstanding request
    // and a scheduled ack edge; registers are plain variables.
    int unsigned   cyc = 0;
    bit            m_busy   [N];
    int unsigned   m_ack_at [N];
    bit            m_wr     [N];
    logic [AW-1:0] m_addr   [N];
    logic [31:0]   m_wdata  [N];
    logic [31:0]   m_status [N];
    logic [7:0]    m_ctrl   [N];
    logic [7:0]    m_flags  [N];
    logic [7:0]    m_mask   [N];
    logic [31:0]   m_scratch[N];
    logic [31:0]   m_wcnt   [N];
    bit            e_ack    [N];
    bit            e_err    [N];
    logic [31:0]   e_rdata  [N];
    bit            e_irq    [N];

    function automatic bit addr_err(logic [AW-1:0] a);
        return (a[AW-1:8] != '0) || (a[7:0] >= 8'h1C);
    endfunction

    function automatic logic [31:0] reg_read(int i, logic [AW-1:0] a, logic [31:0] st);
        case (a[7:0] & 8'hFC)
            8'h00: return ID;
            8'h04: return {24'h0, m_ctrl[i]};
            8'h08: return st;
            8'h0C: return {24'h0, m_flags[i]};
            8'h10: return {24'h0, m_mask[i]};
            8'h14: return m_scratch[i];
            8'h18: return m_wcnt[i];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit leaving;
        bit entering;
        logic [7:0] fo, mo, clr;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!rstn[i]) begin
                m_busy[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_rdata[i] = 0; e_irq[i] = 0;
                m_ctrl[i] = 0; m_flags[i] = 0; m_mask[i] = 0; m_scratch[i] = 0; m_wcnt[i] = 0;
            end else begin
                leaving = e_ack[i];
                fo = m_flags[i];
                mo = m_mask[i];
                clr = 8'h00;
                if (!m_busy[i] && (wen[i] || ren[i])) begin
                    m_busy[i] = 1; m_ack_at[i] = cyc + lat_of(i);
                    m_wr[i] = wen[i]; m_addr[i] = addr[i];
                    m_wdata[i] = wdata[i]; m_status[i] = status[i];
                end
                entering = m_busy[i] && !leaving && (cyc == m_ack_at[i]);
                if (entering) begin
                    e_err[i]   = addr_err(m_addr[i]);
                    e_rdata[i] = e_err[i] ? 32'h0 : reg_read(i, m_addr[i], m_status[i]);
                end
                e_ack[i] = entering;
                if (leaving) begin
                    m_busy[i] = 0;
                    if (m_wr[i] && !addr_err(m_addr[i])) begin
                        m_wcnt[i]++;
                        case (m_addr[i][7:0] & 8'hFC)
                            8'h04: m_ctrl[i] = m_wdata[i][7:0];
                            8'h0C: clr = m_wdata[i][7:0];
                            8'h10: m_mask[i] = m_wdata[i][7:0];
                            8'h14: m_scratch[i] = m_wdata[i];
                            default: ;
                        endcase
                    end
                end
                m_flags[i] = (fo & ~clr) | evt[i];
                e_irq[i] = |(fo & mo);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("ack[%0d]", i), ack[i], e_ack[i]);
                check($sformatf("err[%0d]", i), err[i], e_ack[i] & e_err[i]);
                check($sformatf("rdata[%0d]", i), rdata[i], e_rdata[i]);
                check($sformatf("ctrl[%0d]", i), ctrl[i], m_ctrl[i]);
                check($sformatf("irq[%0d]", i), irq[i], e_irq[i]);
            end
        end
    end

    task automatic txn(int i, bit w, bit r, logic [AW-1:0] a, logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int n);
        @(negedge clk);
        addr[i] = a; wdata[i] = d; wen[i] = w; ren[i] = r;
        @(negedge clk);
        wen[i] = 0; ren[i] = 0;
        n = 1;
        while (!ack[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ack[i]) check($sformatf("ack_timeout[%0d]", i), ack[i], 1);
        rd = rdata[i];
        er = err[i];
    endtask

    task automatic count_acks(int i, int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ack[i]) cnt++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        int          cnt;
        for (int i = 0; i < N; i++) begin
            rstn[i] = 0; addr[i] = 0; wdata[i] = 0; wen[i] = 0; ren[i] = 0;
            evt[i] = 0; status[i] = 32'h1357_9BDF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        started = 1;
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_ctrl", ctrl[0], 32'h0);
        for (int i = 0; i < N; i++) rstn[i] = 1;

        txn(0, 0, 1, 20'h00, 0, rd, er, n);
        check("id_lat1", n, 2);
        check("id_rdata", rd, ID);
        check("id_err", er, 0);
        txn(0, 1, 0, 20'h14, 32'hA5A5_1234, rd, er, n);
        txn(0, 0, 1, 20'h14, 0, rd, er, n);
        check("scratch_rb", rd, 32'hA5A5_1234);
        txn(0, 1, 0, 20'h04, 32'h0000_01FF, rd, er, n);
        @(negedge clk);
        check("ctrl_o", ctrl[0], 32'hFF);
        txn(0, 0, 1, 20'h04, 0, rd, er, n);
        check("ctrl_rb", rd, 32'hFF);
        txn(0, 0, 1, 20'h18, 0, rd, er, n);
        check("wcnt2", rd, 2);

        txn(0, 1, 0, 20'h10, 32'h1, rd, er, n);
        @(negedge clk); evt[0] = 8'h01;
        @(negedge clk); evt[0] = 8'h00;
        check("irq_before", irq[0], 0);
        @(negedge clk);
        check("irq_set", irq[0], 1);
        evt[0] = 8'h01;
        txn(0, 1, 0, 20'h0C, 32'h1, rd, er, n);
        @(negedge clk); evt[0] = 8'h00;
        txn(0, 0, 1, 20'h0C, 0, rd, er, n);
        check("flag_set_wins", rd, 1);
        txn(0, 1, 0, 20'h0C, 32'h1, rd, er, n);
        @(negedge clk);
        check("irq_hold", irq[0], 1);
        @(negedge clk);
        check("irq_clr", irq[0], 0);

        txn(0, 1, 0, 20'h1C, 32'hFFFF_FFFF, rd, er, n);
        check("derr_err", er, 1);
        check("derr_rdata", rd, 0);
        txn(0, 0, 1, 20'h18, 0, rd, er, n);
        check("wcnt5", rd, 5);
        txn(0, 0, 1, 20'h100, 0, rd, er, n);
        check("derr_hi", er, 1);

        txn(1, 0, 1, 20'h00, 0, rd, er, n);
        check("lat0", n, 1);
        check("lat0_rdata", rd, ID);
        txn(2, 0, 1, 20'h00, 0, rd, er, n);
        check("lat7", n, 8);

        @(negedge clk); addr[2] = 20'h00; ren[2] = 1;
        @(negedge clk); ren[2] = 0;
        @(negedge clk); addr[2] = 20'h14; ren[2] = 1;
        @(negedge clk); ren[2] = 0;
        count_acks(2, 16, cnt);
        check("extra_ren_acks", cnt, 1);

        txn(2, 1, 1, 20'h14, 32'hCAFE_0001, rd, er, n);
        txn(2, 0, 1, 20'h14, 0, rd, er, n);
        check("wen_ren_write", rd, 32'hCAFE_0001);

        @(negedge clk); addr[2] = 20'h14; wdata[2] = 32'h55; wen[2] = 1;
        @(negedge clk); wen[2] = 0;
        @(negedge clk);
        @(negedge clk); rstn[2] = 0;
        @(negedge clk); rstn[2] = 1;
        check("rst_ack", ack[2], 0);
        check("rst_rdata2", rdata[2], 0);
        check("rst_irq", irq[2], 0);
        count_acks(2, 12, cnt);
        check("rst_no_ack", cnt, 0);
        txn(2, 0, 1, 20'h14, 0, rd, er, n);
        check("rst_scratch", rd, 0);
        check("rst_lat", n, 8);

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                status[i] = $urandom;
                evt[i]    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
                wen[i]    = ($urandom_range(0, 3) == 0);
                ren[i]    = ($urandom_range(0, 3) == 0);
                wdata[i]  = $urandom;
                addr[i]   = ($urandom_range(0, 15) == 0) ? 20'($urandom)
                                                         : 20'($urandom_range(0, 8'h1F));
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            wen[i] = 0; ren[i] = 0; evt[i] = 0;
        end
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
